// File: rtl/sobel_ahb_master.sv
// AHB-Lite initiator for the Sobel slave: one window write, then one result read, per request.
// Optional read-data timeout is compiled in with `define SOBEL_MASTER_TIMEOUT_EN.
module sobel_ahb_master #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_pixels,
    input  logic [3:0]  req_brightness,
    output logic        res_valid,
    output logic [3:0]  res_pixel,
    output logic        err,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [67:0] HWDATA,
    input  logic        HREADY,
    input  logic [67:0] HRDATA
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_DATA
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [67:0] hwdata_q, hwdata_d;
    logic        res_valid_q, res_valid_d;
    logic [3:0]  res_pixel_q, res_pixel_d;
    logic        accept;
    logic        rd_done;

`ifdef SOBEL_MASTER_TIMEOUT_EN
    localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 8) ? 8 : ((CNT_W_RAW > 16) ? 16 : CNT_W_RAW);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q;
    logic             tmo_hit;
    logic             timeout;

    // The wait that reaches the limit aborts on its own edge instead of counting once more.
    assign tmo_hit = !HREADY && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_RD_DATA && !HREADY) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= timeout;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state and bus-phase decode.
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rd_done = 1'b0;
`ifdef SOBEL_MASTER_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = S_WR_ADDR;
                end
            end
            S_WR_ADDR: if (HREADY) state_d = S_WR_DATA;
            S_WR_DATA: if (HREADY) state_d = S_RD_ADDR;
            S_RD_ADDR: if (HREADY) state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (HREADY) begin
                    rd_done = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef SOBEL_MASTER_TIMEOUT_EN
                else if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered, so they are computed from the state being entered.
    always_comb begin
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        htrans_d    = HTRANS_IDLE;
        hwdata_d    = hwdata_q;
        res_valid_d = rd_done;
        res_pixel_d = res_pixel_q;

        if (state_d == S_WR_ADDR) begin
            haddr_d  = BASE_ADDR;
            hwrite_d = 1'b1;
            htrans_d = HTRANS_NONSEQ;
        end else if (state_d == S_RD_ADDR) begin
            haddr_d  = BASE_ADDR + 32'd4;
            hwrite_d = 1'b0;
            htrans_d = HTRANS_NONSEQ;
        end

        if (accept) begin
            hwdata_d = {req_pixels, req_brightness};
        end
        if (rd_done) begin
            res_pixel_d = HRDATA[3:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            res_valid_q <= 1'b0;
            res_pixel_q <= '0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            res_valid_q <= res_valid_d;
            res_pixel_q <= res_pixel_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = 3'b011;
    assign HWDATA    = hwdata_q;
    assign res_valid = res_valid_q;
    assign res_pixel = res_pixel_q;

    // Only the low nibble of read data carries the result pixel.
    logic unused_ok;
    assign unused_ok = ^{HRDATA[67:4], TIMEOUT_CYCLES};

endmodule
